// File: rtl/lagd_ising_job_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lagd_ising_job_sched_pkg
//  Description : Shared types and defaults for the Ising-core job scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package lagd_ising_job_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE      = 2'd0,
        SCHED_RUN       = 2'd1,
        SCHED_DONE_PEND = 2'd2
    } sched_core_state_e;

    localparam int c_SCHED_JOB_ID_W    = 8;
    localparam int c_SCHED_CFG_W       = 32;
    localparam int c_SCHED_QUEUE_DEPTH = 4;
    localparam int c_SCHED_TIMEOUT_W   = 16;

    typedef struct packed {
        logic [c_SCHED_JOB_ID_W-1:0] id;
        logic [c_SCHED_CFG_W-1:0]    cfg;
    } sched_job_t;

    // Round-robin pointer advance: the slot after idx, wrapping at n.
    function automatic int unsigned sched_next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lagd_ising_job_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : lagd_ising_job_sched_rr_pick
//  Description : Combinational round-robin pick: first request at or after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module lagd_ising_job_sched_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Descending scan leaves the lowest match overall and the lowest match >= ptr.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        o_valid    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid  = 1'b1;
                w_lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end
            end
        end
        o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_gnt[i] = o_valid && (o_idx == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/lagd_ising_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : lagd_ising_job_sched
//  Description : Job queue + round-robin dispatch/completion for Ising cores.
//                Optional per-core watchdog under LAGD_SCHED_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lagd_ising_job_sched
    import lagd_ising_job_sched_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int JOB_ID_WIDTH = c_SCHED_JOB_ID_W,
    parameter int CFG_WIDTH    = c_SCHED_CFG_W,
    parameter int QUEUE_DEPTH  = c_SCHED_QUEUE_DEPTH,
    parameter int TIMEOUT_W    = c_SCHED_TIMEOUT_W,
    localparam int CORE_IW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [JOB_ID_WIDTH-1:0] job_id_i,
    input  logic [CFG_WIDTH-1:0]    job_cfg_i,
    output logic [NUM_CORES-1:0]    core_start_o,
    output logic [CFG_WIDTH-1:0]    core_cfg_o,
    input  logic [NUM_CORES-1:0]    core_done_i,
    output logic [NUM_CORES-1:0]    core_abort_o,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles_i,
    output logic                    cmpl_valid_o,
    input  logic                    cmpl_ready_i,
    output logic [JOB_ID_WIDTH-1:0] cmpl_id_o,
    output logic [CORE_IW-1:0]      cmpl_core_o,
    output logic                    cmpl_timeout_o,
    output logic [NUM_CORES-1:0]    core_busy_o,
    output logic                    spurious_o
);

    localparam int QAW = $clog2(QUEUE_DEPTH);

    logic [JOB_ID_WIDTH-1:0] r_q_id  [QUEUE_DEPTH];
    logic [CFG_WIDTH-1:0]    r_q_cfg [QUEUE_DEPTH];
    logic [QAW-1:0]          r_wr, r_rd;
    logic [QAW:0]            r_cnt;
    logic                    w_full, w_empty, w_push, w_pop;

    sched_core_state_e       r_state [NUM_CORES];
    logic [JOB_ID_WIDTH-1:0] r_id    [NUM_CORES];
    logic [NUM_CORES-1:0]    r_tmo;
    logic                    r_spur;
    logic [CORE_IW-1:0]      r_start_ptr, r_cmpl_ptr, r_hold_idx;
    logic                    r_hold;

    logic [NUM_CORES-1:0]    w_idle, w_pend, w_start, w_expire, w_cmpl_clr;
    logic [NUM_CORES-1:0]    w_disp_gnt, w_unused_cmpl_gnt;
    logic [CORE_IW-1:0]      w_disp_idx, w_cpick_idx, w_cmpl_sel;
    logic                    w_disp_ok, w_cpick_valid, w_cmpl_valid, w_cmpl_hs;

    assign w_full      = (r_cnt == (QAW+1)'(QUEUE_DEPTH));
    assign w_empty     = (r_cnt == '0);
    assign w_push      = job_valid_i && !w_full;
    assign w_pop       = !w_empty && w_disp_ok;
    assign job_ready_o = !w_full;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_id[r_wr]  <= job_id_i;
            r_q_cfg[r_wr] <= job_cfg_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + QAW'(1);
            if (w_pop)  r_rd <= r_rd + QAW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (QAW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (QAW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        w_idle = '0;
        w_pend = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_idle[c] = (r_state[c] == SCHED_IDLE);
            w_pend[c] = (r_state[c] == SCHED_DONE_PEND);
        end
    end
    assign core_busy_o = ~w_idle;

    lagd_ising_job_sched_rr_pick #(.NUM_REQ(NUM_CORES)) u_disp_pick (
        .i_req   (w_idle),
        .i_ptr   (r_start_ptr),
        .o_gnt   (w_disp_gnt),
        .o_idx   (w_disp_idx),
        .o_valid (w_disp_ok)
    );

    lagd_ising_job_sched_rr_pick #(.NUM_REQ(NUM_CORES)) u_cmpl_pick (
        .i_req   (w_pend),
        .i_ptr   (r_cmpl_ptr),
        .o_gnt   (w_unused_cmpl_gnt),
        .o_idx   (w_cpick_idx),
        .o_valid (w_cpick_valid)
    );

    assign w_start      = w_pop ? w_disp_gnt : '0;
    assign core_start_o = w_start;
    assign core_cfg_o   = w_pop ? r_q_cfg[r_rd] : '0;

    // A presented completion is locked until accepted so late arrivals cannot reorder it.
    assign w_cmpl_valid   = r_hold || w_cpick_valid;
    assign w_cmpl_sel     = r_hold ? r_hold_idx : w_cpick_idx;
    assign w_cmpl_hs      = w_cmpl_valid && cmpl_ready_i;
    assign cmpl_valid_o   = w_cmpl_valid;
    assign cmpl_id_o      = w_cmpl_valid ? r_id[w_cmpl_sel] : '0;
    assign cmpl_core_o    = w_cmpl_valid ? w_cmpl_sel : '0;
    assign cmpl_timeout_o = w_cmpl_valid && r_tmo[w_cmpl_sel];
    assign spurious_o     = r_spur;

    always_comb begin
        w_cmpl_clr = '0;
        if (w_cmpl_hs) w_cmpl_clr[w_cmpl_sel] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold      <= 1'b0;
            r_hold_idx  <= '0;
            r_cmpl_ptr  <= '0;
            r_start_ptr <= '0;
        end else begin
            if (w_pop) r_start_ptr <= CORE_IW'(sched_next_idx(32'(w_disp_idx), NUM_CORES));
            if (w_cmpl_hs) begin
                r_hold     <= 1'b0;
                r_cmpl_ptr <= CORE_IW'(sched_next_idx(32'(w_cmpl_sel), NUM_CORES));
            end else if (w_cmpl_valid) begin
                r_hold     <= 1'b1;
                r_hold_idx <= w_cmpl_sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo  <= '0;
            r_spur <= 1'b0;
            for (int c = 0; c < NUM_CORES; c++) begin
                r_state[c] <= SCHED_IDLE;
                r_id[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (core_done_i[c] && r_state[c] != SCHED_RUN) r_spur <= 1'b1;
                if (w_start[c]) begin
                    r_state[c] <= SCHED_RUN;
                    r_id[c]    <= r_q_id[r_rd];
                    r_tmo[c]   <= 1'b0;
                end else if (r_state[c] == SCHED_RUN) begin
                    if (core_done_i[c]) begin
                        r_state[c] <= SCHED_DONE_PEND;
                        r_tmo[c]   <= 1'b0;
                    end else if (w_expire[c]) begin
                        r_state[c] <= SCHED_DONE_PEND;
                        r_tmo[c]   <= 1'b1;
                    end
                end else if (w_cmpl_clr[c]) begin
                    r_state[c] <= SCHED_IDLE;
                end
            end
        end
    end

`ifdef LAGD_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] r_wd_cnt [NUM_CORES];
    logic [NUM_CORES-1:0] r_wd_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_en <= '0;
            for (int c = 0; c < NUM_CORES; c++) r_wd_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (w_start[c]) begin
                    r_wd_cnt[c] <= timeout_cycles_i;
                    r_wd_en[c]  <= |timeout_cycles_i;
                end else if (r_state[c] == SCHED_RUN && r_wd_en[c] && r_wd_cnt[c] != '0) begin
                    r_wd_cnt[c] <= r_wd_cnt[c] - TIMEOUT_W'(1);
                end
            end
        end
    end

    // Expiry is the cycle the count would reach zero; a same-cycle done takes precedence.
    always_comb begin
        w_expire = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_expire[c] = (r_state[c] == SCHED_RUN) && r_wd_en[c] &&
                          (r_wd_cnt[c] == TIMEOUT_W'(1)) && !core_done_i[c];
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^timeout_cycles_i;
    assign w_expire         = '0;
`endif
    assign core_abort_o = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_lagd_ising_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lagd_ising_job_sched
//  Description : Self-checking bench: per-cycle reference model plus directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lagd_ising_job_sched;

    localparam int N  = 4;
    localparam int QD = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        job_valid = 1'b0, job_ready;
    logic [7:0]  job_id = '0;
    logic [31:0] job_cfg = '0;
    logic [N-1:0] core_start, core_done = '0, core_abort, core_busy;
    logic [31:0] core_cfg;
    logic [15:0] timeout = '0;
    logic        cmpl_valid, cmpl_ready = 1'b0, cmpl_timeout, spurious;
    logic [7:0]  cmpl_id;
    logic [1:0]  cmpl_core;

    lagd_ising_job_sched dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_id_i(job_id), .job_cfg_i(job_cfg),
        .core_start_o(core_start), .core_cfg_o(core_cfg), .core_done_i(core_done),
        .core_abort_o(core_abort), .timeout_cycles_i(timeout),
        .cmpl_valid_o(cmpl_valid), .cmpl_ready_i(cmpl_ready), .cmpl_id_o(cmpl_id),
        .cmpl_core_o(cmpl_core), .cmpl_timeout_o(cmpl_timeout),
        .core_busy_o(core_busy), .spurious_o(spurious)
    );

    always #5 clk = ~clk;

    int nerr = 0, nchk = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: job list, per-core status (0 idle, 1 running, 2 awaiting completion).
    typedef struct { logic [7:0] id; logic [31:0] cfg; } job_t;
    job_t       mq[$];
    int         mst [N];
    logic [7:0] mid [N];
    bit         mtmo[N];
    int         msptr = 0, mcptr = 0, mheld = -1;
    bit         mspur = 0;
    longint     cyc = 0;
`ifdef LAGD_SCHED_WATCHDOG_EN
    longint     mdl [N];
`endif

    always @(negedge clk) begin
        int dc, cc;
        bit can_push;
        logic [N-1:0] e_start, e_abort, e_busy, pre_run;
        job_t j;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            msptr = 0; mcptr = 0; mheld = -1; mspur = 0;
            for (int c = 0; c < N; c++) begin mst[c] = 0; mtmo[c] = 0; end
            chk("rst_ready", job_ready, 1);
            chk("rst_ctrl", {core_start, core_abort, cmpl_valid, cmpl_timeout, core_busy, spurious}, 0);
            chk("rst_data", {core_cfg, cmpl_id, cmpl_core}, 0);
        end else begin
            dc = -1; cc = -1;
            if (mq.size() > 0)
                for (int k = 0; k < N; k++)
                    if (dc < 0 && mst[(msptr + k) % N] == 0) dc = (msptr + k) % N;
            if (mheld >= 0) cc = mheld;
            else for (int k = 0; k < N; k++)
                if (cc < 0 && mst[(mcptr + k) % N] == 2) cc = (mcptr + k) % N;
            e_start = '0; e_abort = '0;
            if (dc >= 0) e_start[dc] = 1'b1;
            for (int c = 0; c < N; c++) begin
                e_busy[c]  = (mst[c] != 0);
                pre_run[c] = (mst[c] == 1);
`ifdef LAGD_SCHED_WATCHDOG_EN
                e_abort[c] = pre_run[c] && mdl[c] == cyc && !core_done[c];
`endif
            end
            can_push = mq.size() < QD;
            chk("job_ready", job_ready, can_push);
            chk("core_start", core_start, e_start);
            if (dc >= 0) chk("core_cfg", core_cfg, mq[0].cfg);
            chk("core_abort", core_abort, e_abort);
            chk("core_busy", core_busy, e_busy);
            chk("spurious", spurious, mspur);
            chk("cmpl_valid", cmpl_valid, cc >= 0);
            if (cc >= 0) begin
                chk("cmpl_id", cmpl_id, mid[cc]);
                chk("cmpl_core", cmpl_core, cc);
                chk("cmpl_timeout", cmpl_timeout, mtmo[cc]);
            end
            if (dc >= 0) begin
                j = mq.pop_front();
                mst[dc] = 1; mid[dc] = j.id; mtmo[dc] = 0; msptr = (dc + 1) % N;
`ifdef LAGD_SCHED_WATCHDOG_EN
                mdl[dc] = (timeout != 0) ? cyc + longint'(timeout) : -1;
`endif
            end
            if (job_valid && can_push) begin
                j.id = job_id; j.cfg = job_cfg;
                mq.push_back(j);
            end
            for (int c = 0; c < N; c++) begin
                if (core_done[c]) begin
                    if (pre_run[c]) begin mst[c] = 2; mtmo[c] = 0; end
                    else mspur = 1;
                end else if (e_abort[c]) begin
                    mst[c] = 2; mtmo[c] = 1;
                end
            end
            if (cc >= 0) begin
                if (cmpl_ready) begin mst[cc] = 0; mcptr = (cc + 1) % N; mheld = -1; end
                else mheld = cc;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        job_valid = 0; core_done = '0; cmpl_ready = 0; timeout = '0;
        rst_n = 0; tick(); tick();
        chk("rst_ready_lit", job_ready, 1);
        chk("rst_busy_lit", {core_busy, spurious, cmpl_valid}, 0);
        rst_n = 1;
    endtask

    initial begin
        int  nacc;
        bit  acc;
        tick(); tick();
        do_reset();

        // Single job on core 0, then complete it
        job_valid = 1; job_id = 8'h11; job_cfg = 32'hA000; tick(); job_valid = 0; #1;
        chk("t1_start", core_start, 4'b0001);
        chk("t1_cfg", core_cfg, 32'hA000);
        tick(); core_done = 4'b0001; tick(); core_done = '0; cmpl_ready = 1; #1;
        chk("t1_cvalid", cmpl_valid, 1);
        chk("t1_cid", cmpl_id, 8'h11);
        chk("t1_ccore", cmpl_core, 0);
        tick(); cmpl_ready = 0; #1;
        chk("t1_after", {cmpl_valid, core_busy}, 0);

        // Five back-to-back jobs land on cores 0..3, fifth stays queued
        do_reset();
        for (int k = 0; k < 6; k++) begin
            job_valid = (k < 5); job_id = 8'h20 + 8'(k); job_cfg = 32'hB000 + k; #1;
            chk("t2_start", core_start, (k >= 1 && k <= 4) ? (4'b0001 << (k - 1)) : 4'b0000);
            chk("t2_ready", job_ready, 1);
            tick();
        end
        job_valid = 0; #1;
        chk("t2_busy", core_busy, 4'b1111);

        // Fill the queue while all cores are busy; held job must survive
        job_valid = 1; job_id = 8'h30; nacc = 0;
        for (int k = 0; k < 8; k++) begin
            #1; acc = job_ready; tick();
            if (acc) begin nacc++; job_id = job_id + 8'd1; end
        end
        chk("t3_accepted", nacc, 3);
        chk("t3_full", job_ready, 0);
        core_done = 4'b0010; tick(); core_done = '0; cmpl_ready = 1; tick(); cmpl_ready = 0; #1;
        chk("t3_redispatch", core_start, 4'b0010);
        tick(); #1;
        chk("t3_ready_again", job_ready, 1);
        tick(); job_valid = 0;

        // Reset mid-run, then four simultaneous dones drain in core order
        do_reset();
        for (int k = 0; k < 4; k++) begin
            job_valid = 1; job_id = 8'h40 + 8'(k); job_cfg = 32'hC000 + k; tick();
        end
        job_valid = 0; tick(); tick();
        core_done = 4'b1111; tick(); core_done = '0; #1;
        chk("t4_hold0_core", cmpl_core, 0);
        tick(); #1;
        chk("t4_hold1_core", cmpl_core, 0);
        chk("t4_hold1_id", cmpl_id, 8'h40);
        cmpl_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_valid", cmpl_valid, 1);
            chk("t4_core", cmpl_core, k);
            chk("t4_id", cmpl_id, 8'h40 + k);
            tick();
        end
        cmpl_ready = 0; #1;
        chk("t4_drained", cmpl_valid, 0);

        // Done on an idle core
        chk("t5_spur_before", spurious, 0);
        core_done = 4'b0100; tick(); core_done = '0; #1;
        chk("t5_spur", spurious, 1);
        chk("t5_nocmpl", cmpl_valid, 0);
        tick(); #1;
        chk("t5_sticky", spurious, 1);

`ifdef LAGD_SCHED_WATCHDOG_EN
        do_reset();
        timeout = 16'd10;
        job_valid = 1; job_id = 8'h50; job_cfg = 32'h1; tick(); job_valid = 0; #1;
        chk("wd_start", core_start, 4'b0001);
        for (int k = 1; k <= 10; k++) begin
            tick(); #1;
            chk("wd_abort", core_abort, (k == 10) ? 4'b0001 : 4'b0000);
        end
        tick(); cmpl_ready = 1; #1;
        chk("wd_cvalid", cmpl_valid, 1);
        chk("wd_tmo", cmpl_timeout, 1);
        tick(); cmpl_ready = 0;
        job_valid = 1; job_id = 8'h51; tick(); job_valid = 0; #1;
        chk("wd2_start", core_start, 4'b0010);
        for (int k = 1; k <= 9; k++) tick();
        tick(); core_done = 4'b0010; #1;
        chk("wd2_noabort", core_abort, 0);
        tick(); core_done = '0; cmpl_ready = 1; #1;
        chk("wd2_core", cmpl_core, 1);
        chk("wd2_tmo", cmpl_timeout, 0);
        tick(); cmpl_ready = 0;
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000 && nerr <= 40; n++) begin
            if (n == 1500) do_reset();
            job_valid  = ($urandom % 3) != 0;
            job_id     = 8'($urandom);
            job_cfg    = $urandom;
            cmpl_ready = $urandom % 2;
            timeout    = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom_range(1, 25));
            core_done  = '0;
            for (int c = 0; c < N; c++)
                if (mst[c] == 1 && $urandom % 6 == 0) core_done[c] = 1'b1;
            if ($urandom % 400 == 0) core_done[$urandom % N] = 1'b1;
            tick();
        end
        job_valid = 0; core_done = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
